// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames ASCII commands "<start><cmd><hex...><end>" from the UART
// receiver and issues one (addr, data) write to the DDS configuration bus over a
// valid/ready handshake. Malformed or stalled frames produce one err_pulse each.
module uart_cmd_ctrl #(
   parameter int         DATA_W      = 32,
   parameter logic [7:0] START_CHAR  = 8'h2E,
   parameter logic [7:0] END_CHAR    = 8'h0D,
   parameter int         TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_flag,
   output logic              cfg_valid,
   input  logic              cfg_ready,
   output logic [1:0]        cfg_addr,
   output logic [DATA_W-1:0] cfg_data,
   output logic              err_pulse,
   output logic              busy
);

   localparam int MAX_DIG = DATA_W / 4;
   localparam int NDIG_W  = $clog2(MAX_DIG + 1);
   localparam int TMR_W   = $clog2(TIMEOUT_CYC);
   localparam logic [NDIG_W-1:0] NDIG_FULL = NDIG_W'(MAX_DIG);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_DIGIT, S_ISSUE, S_ERROR} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   acc;
   logic [NDIG_W-1:0]   ndig;
   logic                err_sticky;
   logic [TMR_W-1:0]    timer;
   logic [1:0]          addr_lat;
   logic [2:0]          cmd_dec;

   logic clr_frame, shift_dig, set_err, latch_cmd, load_out, tmr_clr, tmr_inc;

   // True for ASCII 0-9, A-F, a-f.
   function automatic logic is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
             (b >= 8'h61 && b <= 8'h66);
   endfunction

   // Nibble value of a hex character; letters have bit 6 set and a low nibble of 1..6.
   function automatic logic [3:0] hex_nib(input logic [7:0] b);
      return b[3:0] + (b[6] ? 4'd9 : 4'd0);
   endfunction

   // {hit, addr} for the command letter, case-insensitive.
   function automatic logic [2:0] cmd_decode(input logic [7:0] b);
      case (b)
         8'h46, 8'h66: return 3'b100;
         8'h50, 8'h70: return 3'b101;
         8'h41, 8'h61: return 3'b110;
         8'h57, 8'h77: return 3'b111;
         default:      return 3'b000;
      endcase
   endfunction

   assign cmd_dec = cmd_decode(rx_data);

   // State register; reset aborts any frame or pending write outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_nxt = state;
      clr_frame = 1'b0;
      shift_dig = 1'b0;
      set_err   = 1'b0;
      latch_cmd = 1'b0;
      load_out  = 1'b0;
      tmr_clr   = 1'b0;
      tmr_inc   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (rx_flag && rx_data == START_CHAR) begin
               state_nxt = S_CMD;
               clr_frame = 1'b1;
            end
         end
         S_CMD, S_DIGIT: begin
            if (rx_flag) begin
               // A byte always wins over the timeout, even on the last cycle.
               tmr_clr = 1'b1;
               if (rx_data == START_CHAR) begin
                  state_nxt = S_CMD;
                  clr_frame = 1'b1;
               end else if (state == S_CMD) begin
                  if (rx_data == END_CHAR) begin
                     state_nxt = S_ERROR;
                  end else begin
                     // Unknown command letters still consume the frame, then fail at the end.
                     state_nxt = S_DIGIT;
                     latch_cmd = cmd_dec[2];
                     set_err   = ~cmd_dec[2];
                  end
               end else if (rx_data == END_CHAR) begin
                  if (err_sticky || ndig == '0) begin
                     state_nxt = S_ERROR;
                  end else begin
                     state_nxt = S_ISSUE;
                     load_out  = 1'b1;
                  end
               end else if (is_hex(rx_data)) begin
                  if (ndig == NDIG_FULL) set_err = 1'b1;
                  else                   shift_dig = 1'b1;
               end else begin
                  set_err = 1'b1;
               end
            end else if (timer == TMR_LAST) begin
               state_nxt = S_ERROR;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         S_ISSUE: begin
            if (cfg_valid && cfg_ready) state_nxt = S_IDLE;
         end
         S_ERROR: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame accumulator, digit count, sticky error, inter-byte timer, command latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         ndig       <= '0;
         err_sticky <= 1'b0;
         timer      <= '0;
         addr_lat   <= '0;
      end else begin
         if (clr_frame) begin
            acc        <= '0;
            ndig       <= '0;
            err_sticky <= 1'b0;
            timer      <= '0;
         end else begin
            if (shift_dig) begin
               acc  <= {acc[DATA_W-5:0], hex_nib(rx_data)};
               ndig <= ndig + 1'b1;
            end
            if (set_err) err_sticky <= 1'b1;
            if (tmr_clr)      timer <= '0;
            else if (tmr_inc) timer <= timer + 1'b1;
         end
         if (latch_cmd) addr_lat <= cmd_dec[1:0];
      end
   end

   // Registered outputs; cfg_valid rises one cycle after entering ISSUE and
   // cfg_addr/cfg_data hold their value until the next accepted frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_valid <= 1'b0;
         cfg_addr  <= '0;
         cfg_data  <= '0;
         err_pulse <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cfg_valid <= (state == S_ISSUE) && (state_nxt == S_ISSUE);
         err_pulse <= (state_nxt == S_ERROR);
         busy      <= (state_nxt != S_IDLE);
         if (load_out) begin
            cfg_addr <= addr_lat;
            cfg_data <= acc;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames, a frame-level reference model that
// judges each completed frame as a whole, and a per-cycle output comparison.
module tb_uart_cmd_ctrl;

   localparam int         DATA_W = 32;
   localparam int         TMO    = 20;
   localparam logic [7:0] SC     = 8'h2E;
   localparam logic [7:0] EC     = 8'h0D;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_flag = 1'b0;
   logic              cfg_valid;
   logic              cfg_ready = 1'b1;
   logic [1:0]        cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   logic              err_pulse;
   logic              busy;

   int checks = 0;
   int errors = 0;

   uart_cmd_ctrl #(
      .DATA_W(DATA_W), .START_CHAR(SC), .END_CHAR(EC), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_flag(rx_flag),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .err_pulse(err_pulse), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   bit                m_frame = 0;   // collecting a frame
   bit                m_err   = 0;   // error pulse cycle
   int                m_issue = 0;   // 0 none, 1 write pending, 2 valid shown
   int                m_silent = 0;  // cycles without a byte inside a frame
   logic [7:0]        fbuf[$];       // bytes since the last start char
   logic [1:0]        m_addr = '0;
   logic [DATA_W-1:0] m_data = '0;

   // observed write / error events
   int                wr_cnt = 0, err_cnt = 0, run = 0, last_run = 0;
   logic [1:0]        last_addr = '0;
   logic [DATA_W-1:0] last_data = '0;

   function automatic int cmd_index(input logic [7:0] c);
      case (c)
         "F", "f": return 0;
         "P", "p": return 1;
         "A", "a": return 2;
         "W", "w": return 3;
         default:  return -1;
      endcase
   endfunction

   function automatic int digit_value(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - int'("0");
      if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
      if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
      return -1;
   endfunction

   // Judge a whole frame body: one command letter followed by 1..DATA_W/4 hex digits.
   task automatic judge();
      bit ok;
      int n, ci, d;
      logic [DATA_W-1:0] v;
      ok = 1;
      v  = '0;
      n  = fbuf.size();
      ci = -1;
      if (n < 2 || n - 1 > DATA_W / 4) ok = 0;
      else begin
         ci = cmd_index(fbuf[0]);
         if (ci < 0) ok = 0;
         for (int i = 1; i < n; i++) begin
            d = digit_value(fbuf[i]);
            if (d < 0) ok = 0;
            else v = v * 16 + DATA_W'(d);
         end
      end
      if (ok) begin
         m_issue = 1;
         m_addr  = 2'(ci);
         m_data  = v;
      end else begin
         m_err = 1;
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_frame = 0; m_err = 0; m_issue = 0; m_silent = 0;
         fbuf.delete();
         m_addr = '0; m_data = '0;
      end else if (m_err) begin
         m_err = 0;
      end else if (m_issue != 0) begin
         if (m_issue == 1)   m_issue = 2;
         else if (cfg_ready) m_issue = 0;
      end else if (!m_frame) begin
         if (rx_flag && rx_data == SC) begin
            m_frame = 1; m_silent = 0; fbuf.delete();
         end
      end else if (rx_flag) begin
         m_silent = 0;
         if (rx_data == SC) fbuf.delete();
         else if (rx_data == EC) begin
            m_frame = 0;
            judge();
         end else fbuf.push_back(rx_data);
      end else if (m_silent == TMO - 1) begin
         m_frame = 0; m_err = 1;
      end else begin
         m_silent++;
      end
   endtask

   // Edge process: record handshakes/pulses, then advance the model.
   initial forever begin
      @(posedge clk or posedge rst);
      if (!rst) begin
         if (cfg_valid && cfg_ready) begin
            wr_cnt++; last_addr = cfg_addr; last_data = cfg_data;
         end
         if (err_pulse) err_cnt++;
         if (cfg_valid) run++;
         else if (run > 0) begin last_run = run; run = 0; end
      end
      model_step();
   end

   // Compare process: every output, every cycle, mid-cycle.
   initial forever begin
      @(negedge clk);
      check("busy",      busy,      64'(m_frame || m_issue != 0 || m_err));
      check("cfg_valid", cfg_valid, 64'(m_issue == 2));
      check("err_pulse", err_pulse, 64'(m_err));
      check("cfg_addr",  cfg_addr,  64'(m_addr));
      check("cfg_data",  cfg_data,  64'(m_data));
   end

   // ---------------- stimulus ----------------
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b; rx_flag = 1'b1;
      @(negedge clk);
      rx_flag = 1'b0; rx_data = 8'h00;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (busy && i < 50) begin @(negedge clk); i++; end
      if (i >= 50) check("wait_idle_timeout", 1, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid();
      int i;
      i = 0;
      while (!cfg_valid && i < 20) begin @(negedge clk); i++; end
      if (i >= 20) check("wait_valid_timeout", 0, 1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, cfg_valid, 0);
      check({tag, "_busy"},  busy,      0);
      check({tag, "_err"},   err_pulse, 0);
      check({tag, "_addr"},  cfg_addr,  0);
      check({tag, "_data"},  cfg_data,  0);
   endtask

   int wr0, er0;

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic write with fixed latency.
      wr0 = wr_cnt; er0 = err_cnt;
      send_str(".F1A2B"); send_byte(EC);
      check("lat_issue_cycle", cfg_valid, 0);
      @(negedge clk);
      check("lat_valid_high", cfg_valid, 1);
      check("t1_addr", cfg_addr, 0);
      check("t1_data", cfg_data, 32'h00001A2B);
      @(negedge clk);
      check("lat_valid_drop", cfg_valid, 0);
      wait_idle();
      check("t1_writes", wr_cnt - wr0, 1);
      check("t1_errs", err_cnt - er0, 0);
      check("t1_last_data", last_data, 32'h00001A2B);

      // Back-pressure: ready low for 5 valid cycles, a byte sent during the stall.
      wr0 = wr_cnt; er0 = err_cnt;
      cfg_ready = 1'b0;
      send_str(".p00FF"); send_byte(EC);
      wait_valid();
      check("t2_addr_1", cfg_addr, 1);
      check("t2_data_1", cfg_data, 32'hFF);
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         check("t2_valid_held", cfg_valid, 1);
         check("t2_addr_stable", cfg_addr, 1);
         check("t2_data_stable", cfg_data, 32'hFF);
         if (k == 2) begin rx_data = SC; rx_flag = 1'b1; end
         if (k == 3) begin rx_flag = 1'b0; rx_data = 8'h00; end
         if (k == 6) cfg_ready = 1'b1;
      end
      @(negedge clk);
      check("t2_valid_drop", cfg_valid, 0);
      wait_idle();
      check("t2_valid_cycles", last_run, 6);
      check("t2_writes", wr_cnt - wr0, 1);
      check("t2_last_addr", last_addr, 1);
      check("t2_errs", err_cnt - er0, 0);

      // Malformed frames: bad command, no digits, too many digits.
      wr0 = wr_cnt; er0 = err_cnt;
      send_str(".X12"); send_byte(EC); wait_idle();
      check("t3_bad_cmd_errs", err_cnt - er0, 1);
      send_str(".F"); send_byte(EC); wait_idle();
      check("t3_no_digit_errs", err_cnt - er0, 2);
      send_str(".F123456789"); send_byte(EC); wait_idle();
      check("t3_overflow_errs", err_cnt - er0, 3);
      check("t3_writes", wr_cnt - wr0, 0);

      // Restart mid-frame.
      wr0 = wr_cnt; er0 = err_cnt;
      send_str(".P1.A3"); send_byte(EC); wait_idle();
      check("t4_writes", wr_cnt - wr0, 1);
      check("t4_addr", last_addr, 2);
      check("t4_data", last_data, 32'h3);
      check("t4_errs", err_cnt - er0, 0);

      // Inter-byte timeout, then a normal frame.
      wr0 = wr_cnt; er0 = err_cnt;
      send_str(".W1");
      repeat (TMO + 5) @(negedge clk);
      check("t5_timeout_errs", err_cnt - er0, 1);
      check("t5_timeout_idle", busy, 0);
      send_str(".W2"); send_byte(EC); wait_idle();
      check("t5_writes", wr_cnt - wr0, 1);
      check("t5_addr", last_addr, 3);
      check("t5_data", last_data, 32'h2);

      // Reset during DIGIT.
      wr0 = wr_cnt; er0 = err_cnt;
      send_str(".F12");
      #2 rst = 1'b1;
      @(negedge clk);
      check_zero_outputs("rst_digit");
      @(negedge clk);
      rst = 1'b0;
      repeat (TMO + 5) @(negedge clk);
      check("t6_writes", wr_cnt - wr0, 0);
      check("t6_errs", err_cnt - er0, 0);

      // Reset during ISSUE.
      cfg_ready = 1'b0;
      send_str(".F5"); send_byte(EC);
      wait_valid();
      #2 rst = 1'b1;
      @(negedge clk);
      check_zero_outputs("rst_issue");
      @(negedge clk);
      rst = 1'b0; cfg_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("t7_writes", wr_cnt - wr0, 0);
      check("t7_errs", err_cnt - er0, 0);

      // Normal operation after reset.
      send_str(".A7"); send_byte(EC); wait_idle();
      check("t8_writes", wr_cnt - wr0, 1);
      check("t8_addr", last_addr, 2);
      check("t8_data", last_data, 32'h7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
